wb_cmd_master: RTL and testbench
================================

// Module: wb_cmd_master
// PURPOSE
//   Single-outstanding bus master sitting directly upstream of our
//   stb/we/adr/sel/dat/ack register slaves. Buffers bus commands from a
//   valid/ready producer in a small FIFO and executes them one at a time
//   on the slave bus. Returns one response per command (read data plus an
//   error flag), with a timeout for slaves that never ack.
// PARAMETERS
//   DEPTH    4    command FIFO entries; power of 2, >= 2
//   TIMEOUT  255  max cycles stb_o may wait for ack_i; 1..2**16-1
// PORTS
//   clk_i       in   1    clock; all logic on rising edge
//   rst_ni      in   1    reset; asynchronous, active-low
//   cmd_valid_i in   1    command present
//   cmd_ready_o out  1    FIFO can accept (= !full)
//   cmd_we_i    in   1    1 = write, 0 = read
//   cmd_adr_i   in   30   word address [31:2]
//   cmd_sel_i   in   4    byte enables
//   cmd_dat_i   in   32   write data
//   rsp_valid_o out  1    response held
//   rsp_ready_i in   1    consumer takes response
//   rsp_dat_o   out  32   read data (0 for writes or on error)
//   rsp_err_o   out  1    1 = timeout
//   stb_o       out  1    bus strobe to slave
//   we_o        out  1    bus write enable
//   adr_o       out  30   bus word address [31:2]
//   sel_o       out  4    bus byte select
//   dat_o       out  32   bus write data
//   dat_i       in   32   bus read data
//   ack_i       in   1    bus acknowledge
//   busy_o      out  1    FSM not IDLE or FIFO not empty
// BEHAVIOUR
//   Reset (rst_ni low, async): FIFO emptied; FSM to IDLE; all outputs 0
//     except cmd_ready_o=1. stb_o drops immediately, even mid-transfer.
//     The in-flight command and any held response are discarded.
//   Command FIFO: push on cmd_valid_i & cmd_ready_o. No fall-through: an
//     entry is poppable the cycle after push. Push and pop in the same
//     cycle are legal when not full. When full, cmd_ready_o=0 and no push.
//   FSM states IDLE, BUS, RESP:
//     IDLE: if FIFO non-empty, pop and register we/adr/sel/dat onto the bus
//       outputs; stb_o=1 next cycle; -> BUS; clear timeout counter.
//     BUS: stb_o and all bus outputs held stable. Counter increments each
//       cycle. On ack_i=1: capture rsp_dat = we ? 0 : dat_i, rsp_err=0.
//       Else, when the count reaches TIMEOUT: rsp_dat=0, rsp_err=1.
//       Either event -> RESP, and stb_o=0 from the next cycle. If ack_i
//       arrives in the timeout cycle, ack wins (err=0).
//     RESP: rsp_valid_o=1, rsp_dat_o/rsp_err_o stable until
//       rsp_valid_o & rsp_ready_i; then -> IDLE.
//   Min latency: push at cycle N -> stb_o at N+2. Ack at cycle M ->
//     rsp_valid_o at M+1. Back-to-back commands separated by >= 1 stb_o=0
//     cycle (RESP->IDLE->BUS).
//   ack_i outside BUS is ignored, including a late ack after a timeout.
//   Counter is 16 bits wide and saturates; it never wraps.
//   FIFO pointers are log2(DEPTH)+1 bits; full/empty are decided by the MSB.
// TESTING
//   1 Write adr=0x10 sel=F dat=0xA5A5_0001; slave acks 1 cycle after stb
//     -> bus shows exact values; rsp_err=0, rsp_dat=0; stb_o high 2 cycles.
//   2 Read adr=0x10; slave returns 0xA5A5_0001 with ack -> rsp_dat_o=
//     0xA5A5_0001, rsp_valid_o held 5 cycles with rsp_ready_i=0, stable.
//   3 Push DEPTH+1 cmds with rsp_ready_i=0 -> cmd_ready_o low after DEPTH
//     more accepted beyond the one in flight; all executed in order once
//     drained.
//   4 TIMEOUT=8, slave never acks -> stb_o high 8 cycles, then rsp_err_o=1,
//     rsp_dat_o=0; ack_i pulsed in RESP has no effect.
//   5 Assert rst_ni low mid-BUS -> stb_o=0 same cycle; after release
//     busy_o=0, rsp_valid_o=0, cmd_ready_o=1.
//   6 ack_i in the timeout cycle -> rsp_err_o=0, read data captured.

Source files
------------

// File: rtl/wb_cmd_master.sv
// Single-outstanding bus master: command FIFO feeding a stb/ack slave bus,
// one response (read data, timeout flag) returned per command.
module wb_cmd_master #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [29:0] cmd_adr_i,
    input  logic [3:0]  cmd_sel_i,
    input  logic [31:0] cmd_dat_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [29:0] adr_o,
    output logic [3:0]  sel_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    output logic        busy_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 1 + 30 + 4 + 32;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    state_t state, state_nx;

    logic [EW-1:0] mem [DEPTH];
    logic [AW:0]   wptr, rptr;
    logic          full, empty, push, pop;
    logic          cap_ack, cap_to;
    logic [15:0]   cnt;
    logic [31:0]   rsp_dat_q;
    logic          rsp_err_q;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
    assign push  = cmd_valid_i && !full;

    assign cmd_ready_o = !full;
    assign stb_o       = (state == BUS);
    assign rsp_valid_o = (state == RESP);
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    assign busy_o      = (state != IDLE) || !empty;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= {cmd_we_i, cmd_adr_i, cmd_sel_i, cmd_dat_i};
        end
    end

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        cap_ack  = 1'b0;
        cap_to   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    state_nx = BUS;
                end
            end
            BUS: begin
                // ack has priority over a timeout in the same cycle
                if (ack_i) begin
                    cap_ack  = 1'b1;
                    state_nx = RESP;
                end else if (cnt == TO_LAST) begin
                    cap_to   = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            wptr      <= '0;
            rptr      <= '0;
            we_o      <= 1'b0;
            adr_o     <= '0;
            sel_o     <= '0;
            dat_o     <= '0;
            cnt       <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
                {we_o, adr_o, sel_o, dat_o} <= mem[rptr[AW-1:0]];
                cnt <= '0;
            end else if (state == BUS && cnt != 16'hFFFF) begin
                cnt <= cnt + 16'd1;
            end
            if (cap_ack) begin
                rsp_dat_q <= we_o ? 32'd0 : dat_i;
                rsp_err_q <= 1'b0;
            end else if (cap_to) begin
                rsp_dat_q <= 32'd0;
                rsp_err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master: the bench plays producer, slave and
// consumer; inputs change and outputs are sampled on the falling edge.
module tb_wb_cmd_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [29:0] cmd_adr;
    logic [3:0]  cmd_sel;
    logic [31:0] cmd_dat;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        stb, we;
    logic [29:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_w, dat_r;
    logic        ack, busy;

    int n_tests = 0;
    int n_fail  = 0;
    int hi;

    always #5 clk = ~clk;

    wb_cmd_master #(.DEPTH(4), .TIMEOUT(8)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_we_i(cmd_we), .cmd_adr_i(cmd_adr),
        .cmd_sel_i(cmd_sel), .cmd_dat_i(cmd_dat),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
        .stb_o(stb), .we_o(we), .adr_o(adr), .sel_o(sel),
        .dat_o(dat_w), .dat_i(dat_r), .ack_i(ack),
        .busy_o(busy)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic w, input logic [29:0] a,
                        input logic [3:0] s, input logic [31:0] d);
        int n = 0;
        cmd_we = w; cmd_adr = a; cmd_sel = s; cmd_dat = d;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("push_bound", 0, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_stb();
        int n = 0;
        while (!stb && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("stb_bound", 0, 1);
    endtask

    task automatic bus_cycle(input int wait_n, input logic [31:0] rd,
                             output int h);
        wait_stb();
        h = 1;
        repeat (wait_n) begin
            @(negedge clk);
            if (stb) h++;
        end
        ack = 1'b1;
        dat_r = rd;
        @(negedge clk);
        ack = 1'b0;
        dat_r = '0;
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        cmd_valid = 0; cmd_we = 0; cmd_adr = '0; cmd_sel = '0;
        cmd_dat = '0; rsp_ready = 0; dat_r = '0; ack = 0;
        repeat (2) @(negedge clk);
        check("rst_ready", cmd_ready, 1);
        check("rst_stb", stb, 0);
        check("rst_rvalid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rdat", rsp_dat, 0);
        check("rst_adr", adr, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // write with ack one cycle after stb
        push(1'b1, 30'h10, 4'hF, 32'hA5A5_0001);
        check("t1_pre_stb", stb, 0);
        check("t1_busy", busy, 1);
        wait_stb();
        check("t1_we", we, 1);
        check("t1_adr", adr, 30'h10);
        check("t1_sel", sel, 4'hF);
        check("t1_dat", dat_w, 32'hA5A5_0001);
        bus_cycle(1, 32'h0BAD_0BAD, hi);
        check("t1_stb_len", hi, 2);
        check("t1_stb_low", stb, 0);
        check("t1_rvalid", rsp_valid, 1);
        check("t1_err", rsp_err, 0);
        check("t1_rdat", rsp_dat, 0);
        take_rsp();
        check("t1_idle", rsp_valid, 0);

        // read, response held under backpressure
        push(1'b0, 30'h10, 4'hF, 32'h0);
        bus_cycle(0, 32'hA5A5_0001, hi);
        check("t2_stb_len", hi, 1);
        check("t2_we", we, 0);
        repeat (5) begin
            check("t2_hold_v", rsp_valid, 1);
            check("t2_hold_d", rsp_dat, 32'hA5A5_0001);
            check("t2_hold_e", rsp_err, 0);
            @(negedge clk);
        end
        take_rsp();

        // fill FIFO behind a stalled transfer
        for (int i = 0; i < 5; i++) begin
            push(1'b0, 30'(32'h20 + i), 4'h3, 32'h0);
        end
        check("t3_full", cmd_ready, 0);
        check("t3_busy", busy, 1);
        for (int i = 0; i < 5; i++) begin
            bus_cycle(0, 32'h1000 + i, hi);
            check("t3_adr", adr, 30'(32'h20 + i));
            check("t3_sel", sel, 4'h3);
            check("t3_rdat", rsp_dat, 32'h1000 + i);
            check("t3_err", rsp_err, 0);
            take_rsp();
        end
        check("t3_ready", cmd_ready, 1);
        check("t3_done", busy, 0);

        // timeout, then a late ack in RESP
        push(1'b1, 30'h30, 4'hF, 32'h1234);
        wait_stb();
        hi = 0;
        while (stb && hi < 40) begin
            hi++;
            @(negedge clk);
        end
        check("t4_stb_len", hi, 8);
        check("t4_rvalid", rsp_valid, 1);
        check("t4_err", rsp_err, 1);
        check("t4_rdat", rsp_dat, 0);
        ack = 1'b1;
        dat_r = 32'hFFFF_FFFF;
        @(negedge clk);
        ack = 1'b0;
        dat_r = '0;
        check("t4_late_err", rsp_err, 1);
        check("t4_late_dat", rsp_dat, 0);
        check("t4_late_v", rsp_valid, 1);
        take_rsp();
        check("t4_stb", stb, 0);
        check("t4_busy", busy, 0);

        // ack in the timeout cycle wins
        push(1'b0, 30'h34, 4'hF, 32'h0);
        bus_cycle(7, 32'hDEAD_BEEF, hi);
        check("t6_stb_len", hi, 8);
        check("t6_err", rsp_err, 0);
        check("t6_rdat", rsp_dat, 32'hDEAD_BEEF);
        take_rsp();

        // async reset mid-transfer with a queued command
        push(1'b0, 30'h40, 4'hF, 32'h0);
        push(1'b0, 30'h44, 4'hF, 32'h0);
        wait_stb();
        #2 rst_n = 1'b0;
        #1;
        check("t5_stb_async", stb, 0);
        check("t5_rvalid", rsp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_busy", busy, 0);
        check("t5_rvalid2", rsp_valid, 0);
        check("t5_ready", cmd_ready, 1);
        @(negedge clk);
        check("t5_stb", stb, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
